// File: rtl/spi_pkg.sv
// Shared types for the SPI master: the FSM state encoding and the latched SPI mode.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

endpackage

// File: rtl/spi_master_core_clk_gen.sv
// SCLK generator: D-cycle window counter, leading/trailing edge strobes and the SCLK level.
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic             shift_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             cpol_i,
   output logic             tick_o,
   output logic             lead_edge_o,
   output logic             trail_edge_o,
   output logic             sclk_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic             sclk_q, sclk_d;
   logic             tick_s;

   assign tick_s       = run_i && (cnt_q == div_i);
   assign tick_o       = tick_s;
   assign lead_edge_o  = shift_i && tick_s && !phase_q;
   assign trail_edge_o = shift_i && tick_s && phase_q;
   assign sclk_o       = sclk_q;

   // Window counter wraps every D cycles; SCLK only toggles at window ends while shifting.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      sclk_d  = sclk_q;
      if (!run_i || tick_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      if (!shift_i) begin
         phase_d = 1'b0;
         sclk_d  = cpol_i;
      end else if (tick_s) begin
         phase_d = ~phase_q;
         sclk_d  = ~sclk_q;
      end else begin
         phase_d = phase_q;
         sclk_d  = sclk_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         sclk_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         sclk_q  <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_master_core.sv
// Parametrised SPI master with TX holding register and acknowledged RX register.
// Optional feature: define SPI_LSB_FIRST_EN to add the lsb_first port.
module spi_master_core
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4,
   parameter int DIV_W  = 8,
   localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              mclk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              ld,
   input  logic              start,
   input  logic [SS_W-1:0]   ss_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic              rd,
   input  logic              miso,
`ifdef SPI_LSB_FIRST_EN
   input  logic              lsb_first,
`endif
   output logic              sclk,
   output logic              mosi,
   output logic [NUM_SS-1:0] ss_n,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] dout,
   output logic              rx_valid,
   output logic              overrun
);

   localparam int CNT_W = $clog2(DATA_W);

   spi_state_t        state_q;
   spi_mode_t         mode_q;
   logic [DIV_W-1:0]  div_q;
   logic              lsb_q;
   logic [DATA_W-1:0] hold_q, sh_q, rx_q, dout_q;
   logic [CNT_W-1:0]  bit_q;
   logic [NUM_SS-1:0] ss_n_q;
   logic              mosi_q, busy_q, done_q, rx_valid_q, overrun_q;

   logic              tick_s, lead_s, trail_s, sclk_s;
   logic              run_s, shift_s, cpol_s, start_ok_s, sample_s, drive_s, lsb_in_s;
   logic [DATA_W-1:0] tx_word_s;

   function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic lsb,
                                                   input logic b);
      return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
   endfunction

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in_s = lsb_first;
`else
   assign lsb_in_s = 1'b0;
`endif

   assign run_s      = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
   assign shift_s    = (state_q == SHIFT);
   assign cpol_s     = (state_q == IDLE) ? cpol : mode_q.cpol;
   assign start_ok_s = (state_q == IDLE) && start && (int'(ss_sel) < NUM_SS);
   // A same-cycle ld bypasses the holding register so the fresh word goes out.
   assign tx_word_s  = ld ? din : hold_q;
   assign sample_s   = mode_q.cpha ? trail_s : lead_s;
   assign drive_s    = mode_q.cpha ? lead_s : trail_s;

   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk_i        (mclk),
      .rst_ni       (rst),
      .run_i        (run_s),
      .shift_i      (shift_s),
      .div_i        (div_q),
      .cpol_i       (cpol_s),
      .tick_o       (tick_s),
      .lead_edge_o  (lead_s),
      .trail_edge_o (trail_s),
      .sclk_o       (sclk_s)
   );

   // Transfer FSM with registered pin and host-side outputs.
   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         mode_q     <= '0;
         div_q      <= '0;
         lsb_q      <= 1'b0;
         hold_q     <= '0;
         sh_q       <= '0;
         rx_q       <= '0;
         dout_q     <= '0;
         bit_q      <= '0;
         ss_n_q     <= '1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (ld) begin
            hold_q <= din;
         end
         if (rd && rx_valid_q) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (start_ok_s) begin
                  state_q     <= SETUP;
                  mode_q.cpol <= cpol;
                  mode_q.cpha <= cpha;
                  div_q       <= clk_div;
                  lsb_q       <= lsb_in_s;
                  sh_q        <= tx_word_s;
                  bit_q       <= '0;
                  busy_q      <= 1'b1;
                  ss_n_q      <= ~(NUM_SS'(1) << ss_sel);
                  if (!cpha) begin
                     mosi_q <= out_bit(tx_word_s, lsb_in_s);
                  end
               end
            end
            SETUP: begin
               if (tick_s) begin
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (sample_s) begin
                  rx_q <= shift_in(rx_q, lsb_q, miso);
               end
               // CPHA=1 presents the current bit; CPHA=0 already showed it and advances.
               if (drive_s) begin
                  sh_q   <= shift_in(sh_q, lsb_q, 1'b0);
                  mosi_q <= mode_q.cpha ? out_bit(sh_q, lsb_q)
                                        : out_bit(shift_in(sh_q, lsb_q, 1'b0), lsb_q);
               end
               if (trail_s) begin
                  if (bit_q == CNT_W'(DATA_W - 1)) begin
                     state_q <= HOLD;
                  end else begin
                     bit_q <= bit_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (tick_s) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  dout_q     <= rx_q;
                  rx_valid_q <= 1'b1;
                  ss_n_q     <= '1;
                  if (rx_valid_q && !rd) begin
                     overrun_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ss_n_q  <= '1;
            end
         endcase
      end
   end

   assign sclk     = sclk_s;
   assign mosi     = mosi_q;
   assign ss_n     = ss_n_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign dout     = dout_q;
   assign rx_valid = rx_valid_q;
   assign overrun  = overrun_q;

endmodule
